voice_mixer: RTL and testbench
==============================

Name: voice_mixer

Overview:
Time-multiplexed polyphonic mixer between the per-note sample BRAMs and the speaker PDM.
- On each sample tick it snapshots the gates and steps a per-voice linear attack/release envelope.
- It reads one sample per voice through a shared BRAM read mux, weights and accumulates the samples, and normalises by the active-voice count.
- It emits one unsigned offset-binary word per tick for the PDM duty-cycle input.

Parameters:
NUM_VOICES, 8, number of note voices/BRAMs.
SAMPLE_WIDTH, 16, signed two's-complement BRAM sample width.
OUT_WIDTH, 10, output word width (matches 1024-level PDM).
READ_LATENCY, 2, cycles from rd_en_out to valid sample_in.
ATTACK_STEP, 8, envelope increment per tick while gated.
RELEASE_STEP, 2, envelope decrement per tick while ungated.

Ports:
clk_in  input  1  system clock (100 MHz).
rst_in  input  1  asynchronous, active-low reset.
sample_tick_in  input  1  one-cycle pulse per audio sample (16,384 Hz).
gate_in  input  NUM_VOICES  per-voice gate from note decoder.
rd_en_out  output  1  BRAM read strobe.
rd_voice_out  output  $clog2(NUM_VOICES)  voice index selecting the BRAM output mux.
sample_in  input  SAMPLE_WIDTH  signed sample of voice rd_voice_out, valid READ_LATENCY cycles after rd_en_out.
mix_out  output  OUT_WIDTH  mixed offset-binary sample, held between updates.
mix_valid_out  output  1  one-cycle pulse when mix_out updates.
busy_out  output  1  high while a frame is in progress.
active_count_out  output  $clog2(NUM_VOICES+1)  voices with nonzero envelope in the current frame.
overrun_out  output  1  sticky: tick arrived while busy.

Behaviour:
- Reset (rst_in=0, async) values:
  - all envelopes 0
  - mix_out = 2^(OUT_WIDTH-1) (512)
  - mix_valid_out, rd_en_out, busy_out, overrun_out = 0
  - rd_voice_out = 0, active_count_out = 0
  - FSM to IDLE
- Reset mid-frame aborts the frame; no valid pulse is issued for it.
- FSM states: IDLE, ISSUE, DRAIN, NORM, OUT.
- IDLE, tick seen at cycle T:
  - Latch the gate_in snapshot.
  - Envelope update, per voice, 8-bit, saturating: gated gives env = min(255, env+ATTACK_STEP); ungated gives env = max(0, env-RELEASE_STEP).
  - active_count_out = number of voices with updated env != 0.
  - Clear the accumulator, set busy_out=1, go to ISSUE.
- Gate changes after the snapshot are ignored until the next tick.
- ISSUE: during cycles T+1..T+NUM_VOICES, assert rd_en_out=1 with rd_voice_out = 0,1,...,NUM_VOICES-1, one voice per cycle. All voices are read, including those with env=0.
- Return path: each returned sample is multiplied signed by zero-extended env, then arithmetic-shifted right by 8, then added to a signed accumulator of width SAMPLE_WIDTH+$clog2(NUM_VOICES)+1.
- DRAIN: wait until the last return (cycle T+NUM_VOICES+READ_LATENCY) is accumulated.
- NORM:
  - Arithmetic right shift by s = ceil(log2(active_count)): count 0/1 → 0, 2 → 1, 3–4 → 2, 5–8 → 3.
  - Saturate to signed SAMPLE_WIDTH.
  - Take the top OUT_WIDTH bits and invert the MSB (offset binary).
  - If active_count = 0, the result is forced to midscale.
- OUT: register mix_out, pulse mix_valid_out for one cycle, clear busy_out, return to IDLE.
- Latency: mix_valid_out is high exactly NUM_VOICES+READ_LATENCY+3 cycles after the tick cycle (13 with defaults).
- Tick while busy (any state except IDLE): the tick is ignored, the current frame completes normally, and overrun_out is set. overrun_out is cleared only by reset.
- Tick coincident with the OUT cycle counts as busy (ignored, overrun set).
- Envelope boundaries: attack clamps at 255; release clamps at 0, and the voice then drops out of active_count.

Test Plan:
1. Hold rst_in=0 then release, no ticks → mix_out=512, mix_valid_out=0, rd_en_out=0, overrun_out=0.
2. gate_in=0x01, voice 0 returns 0x4000 and the others 0; single tick → rd_en_out high 8 cycles with voices 0..7, mix_valid_out 13 cycles after tick, mix_out=520, active_count_out=1. After 32 ticks (env=255) → mix_out=767.
3. gate_in=0x03, voices 0 and 1 return 0x7FFF, envs at 255 → accumulator 65278, shift 1, mix_out=1021, active_count_out=2.
4. From voice 0 at env=255, drop gate_in to 0 → env 253 after next tick. active_count_out reaches 0 on the 128th tick and mix_out=512 from then on; a valid pulse still occurs every tick.
5. Second tick issued 5 cycles after the first → exactly one mix_valid_out pulse at T+13, overrun_out=1 and stays 1 until reset.
6. Assert rst_in=0 at T+6 mid-frame, release, drive no further ticks → no mix_valid_out pulse, mix_out=512, busy_out=0, envelopes 0 (next single gated tick reproduces scenario 2's 520).

Source files
------------

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - time-multiplexed polyphonic voice mixer feeding the speaker PDM
// Steps per-voice envelopes on each sample tick, reads all voices through one BRAM mux and normalises the mix.
module voice_mixer #(
  parameter int NUM_VOICES   = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int OUT_WIDTH    = 10,
  parameter int READ_LATENCY = 2,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              sample_tick_in,
  input  logic [NUM_VOICES-1:0]             gate_in,
  output logic                              rd_en_out,
  output logic [$clog2(NUM_VOICES)-1:0]     rd_voice_out,
  input  logic [SAMPLE_WIDTH-1:0]           sample_in,
  output logic [OUT_WIDTH-1:0]              mix_out,
  output logic                              mix_valid_out,
  output logic                              busy_out,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_count_out,
  output logic                              overrun_out
);
  localparam int VW     = $clog2(NUM_VOICES);
  localparam int CW     = $clog2(NUM_VOICES+1);
  localparam int ACC_W  = SAMPLE_WIDTH + VW + 1;
  localparam int PROD_W = SAMPLE_WIDTH + 9;
  localparam logic [OUT_WIDTH-1:0] MIDSCALE = OUT_WIDTH'(1) << (OUT_WIDTH-1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, NORM, OUT} state_t;

  state_t                   state_q, state_d;
  logic [VW-1:0]            cnt_q, cnt_d;
  logic [7:0]               env_q [NUM_VOICES];
  logic [7:0]               env_d [NUM_VOICES];
  logic [CW-1:0]            active_q, active_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [READ_LATENCY-1:0]  pipe_vld_q;
  logic [VW-1:0]            pipe_voice_q [READ_LATENCY];
  logic [OUT_WIDTH-1:0]     norm_q, mix_q, norm_word;
  logic                     mix_valid_q, overrun_q;

  logic                        tick_accept;
  logic [7:0]                  env_ret;
  logic signed [PROD_W-1:0]    prod;
  logic [CW-1:0]               shift;
  logic signed [ACC_W-1:0]     shifted;
  logic signed [SAMPLE_WIDTH-1:0] sat;

  assign tick_accept = sample_tick_in && (state_q == IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick_in) state_d = ISSUE;
      ISSUE:   if (cnt_q == VW'(NUM_VOICES-1)) state_d = DRAIN;
      DRAIN:   if (cnt_q == VW'(READ_LATENCY-1)) state_d = NORM;
      NORM:    state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en_out    = (state_q == ISSUE);
    rd_voice_out = rd_en_out ? cnt_q : '0;
    busy_out     = (state_q != IDLE);
  end

  // One counter walks the voice index in ISSUE, then times the read-latency wait in DRAIN.
  always_comb begin
    cnt_d = '0;
    if ((state_q == ISSUE || state_q == DRAIN) && state_d == state_q) cnt_d = cnt_q + VW'(1);
  end

  always_comb begin
    active_d = active_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      env_d[v] = env_q[v];
      if (tick_accept) begin
        if (gate_in[v])
          env_d[v] = (9'(env_q[v]) + 9'(ATTACK_STEP) > 9'd255) ? 8'd255 : env_q[v] + 8'(ATTACK_STEP);
        else
          env_d[v] = (env_q[v] < 8'(RELEASE_STEP)) ? 8'd0 : env_q[v] - 8'(RELEASE_STEP);
      end
    end
    if (tick_accept) begin
      active_d = '0;
      for (int v = 0; v < NUM_VOICES; v++)
        if (env_d[v] != 8'd0) active_d = active_d + CW'(1);
    end
  end

  assign env_ret = env_q[pipe_voice_q[READ_LATENCY-1]];
  assign prod    = $signed(sample_in) * $signed({1'b0, env_ret});

  always_comb begin
    acc_d = acc_q;
    if (tick_accept)                         acc_d = '0;
    else if (pipe_vld_q[READ_LATENCY-1])     acc_d = acc_q + ACC_W'(prod >>> 8);
  end

  // Shift by ceil(log2(active voices)), saturate to the sample range, then flip to offset binary.
  always_comb begin
    shift = '0;
    for (int k = 0; k < CW; k++)
      if ((1 << k) < int'(active_q)) shift = CW'(k + 1);
    shifted = acc_q >>> shift;
    if (&shifted[ACC_W-1:SAMPLE_WIDTH-1] || ~|shifted[ACC_W-1:SAMPLE_WIDTH-1])
      sat = shifted[SAMPLE_WIDTH-1:0];
    else
      sat = shifted[ACC_W-1] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}} : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    norm_word = (active_q == '0) ? MIDSCALE : (OUT_WIDTH'(sat >>> (SAMPLE_WIDTH-OUT_WIDTH)) ^ MIDSCALE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q       <= '0;
      active_q    <= '0;
      acc_q       <= '0;
      pipe_vld_q  <= '0;
      norm_q      <= MIDSCALE;
      mix_q       <= MIDSCALE;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) env_q[v] <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipe_voice_q[k] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      acc_q    <= acc_d;
      for (int v = 0; v < NUM_VOICES; v++) env_q[v] <= env_d[v];
      pipe_vld_q[0]   <= rd_en_out;
      pipe_voice_q[0] <= rd_voice_out;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld_q[k]   <= pipe_vld_q[k-1];
        pipe_voice_q[k] <= pipe_voice_q[k-1];
      end
      if (state_q == NORM) norm_q <= norm_word;
      if (state_q == OUT)  mix_q  <= norm_q;
      mix_valid_q <= (state_q == OUT);
      if (sample_tick_in && state_q != IDLE) overrun_q <= 1'b1;
    end
  end

  assign mix_out          = mix_q;
  assign mix_valid_out    = mix_valid_q;
  assign active_count_out = active_q;
  assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - self-checking bench for voice_mixer with a BRAM model and mix scoreboard
module tb_voice_mixer;
  localparam int NV = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        sample_tick_in = 1'b0;
  logic [7:0]  gate_in = '0;
  logic        rd_en_out;
  logic [2:0]  rd_voice_out;
  logic [15:0] sample_in;
  logic [9:0]  mix_out;
  logic        mix_valid_out;
  logic        busy_out;
  logic [3:0]  active_count_out;
  logic        overrun_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int mem   [NV];
  int env_m [NV];

  typedef struct { int mix; int cyc; } exp_t;
  exp_t sb [$];
  exp_t e_m;

  logic       p0 = 1'b0, p1 = 1'b0;
  logic [2:0] v0 = '0, v1 = '0;

  voice_mixer dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_tick_in(sample_tick_in), .gate_in(gate_in),
    .rd_en_out(rd_en_out), .rd_voice_out(rd_voice_out), .sample_in(sample_in),
    .mix_out(mix_out), .mix_valid_out(mix_valid_out), .busy_out(busy_out),
    .active_count_out(active_count_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // BRAM model: data for a strobe appears two cycles later; garbage otherwise.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    p0  <= rd_en_out;
    v0  <= rd_voice_out;
    p1  <= p0;
    v1  <= v0;
  end
  assign sample_in = p1 ? 16'(mem[v1]) : 16'hA5A5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_mix();
    int acc = 0;
    int n = 0;
    int s = 0;
    int val;
    for (int v = 0; v < NV; v++) begin
      acc += (mem[v] * env_m[v]) >>> 8;
      if (env_m[v] != 0) n++;
    end
    if (n == 0) return 512;
    while ((1 << s) < n) s++;
    val = acc >>> s;
    if (val > 32767)  val = 32767;
    if (val < -32768) val = -32768;
    return (val + 32768) >>> 6;
  endfunction

  task automatic do_tick(input bit counted);
    sample_tick_in = 1'b1;
    if (counted) begin
      for (int v = 0; v < NV; v++)
        env_m[v] = gate_in[v] ? ((env_m[v] + 8 > 255) ? 255 : env_m[v] + 8)
                              : ((env_m[v] < 2) ? 0 : env_m[v] - 2);
      sb.push_back('{model_mix(), cyc + 13});
    end
    @(negedge clk_in);
    sample_tick_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy_out) && n < 60) begin
      @(negedge clk_in);
      n++;
    end
    chk("frame_done", 32'(sb.size() == 0 && !busy_out), 1);
  endtask

  always @(negedge clk_in) begin
    if (mix_valid_out === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_valid", 32'(mix_valid_out), 0);
      else begin
        e_m = sb.pop_front();
        chk("sb_mix", 32'(mix_out), e_m.mix);
        chk("sb_latency", cyc, e_m.cyc);
      end
    end
  end

  initial begin
    for (int v = 0; v < NV; v++) begin mem[v] = 0; env_m[v] = 0; end
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_mix", 32'(mix_out), 512);
    chk("rst_valid", 32'(mix_valid_out), 0);
    chk("rst_rd_en", 32'(rd_en_out), 0);
    chk("rst_rd_voice", 32'(rd_voice_out), 0);
    chk("rst_overrun", 32'(overrun_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_active", 32'(active_count_out), 0);

    mem[0] = 16384; gate_in = 8'h01;
    do_tick(1);
    for (int i = 0; i < NV; i++) begin
      chk("issue_rd_en", 32'(rd_en_out), 1);
      chk("issue_voice", 32'(rd_voice_out), i);
      @(negedge clk_in);
    end
    chk("issue_end", 32'(rd_en_out), 0);
    wait_idle();
    chk("s2_mix", 32'(mix_out), 520);
    chk("s2_active", 32'(active_count_out), 1);
    repeat (31) begin do_tick(1); wait_idle(); end
    chk("s2_mix_full", 32'(mix_out), 767);

    mem[0] = 32767; mem[1] = 32767; gate_in = 8'h03;
    repeat (32) begin do_tick(1); wait_idle(); end
    chk("s3_mix", 32'(mix_out), 1021);
    chk("s3_active", 32'(active_count_out), 2);

    mem[1] = -28672; gate_in = 8'h00;
    do_tick(1); wait_idle();
    chk("s4_active_first", 32'(active_count_out), 2);
    repeat (125) begin do_tick(1); wait_idle(); end
    do_tick(1); wait_idle();
    chk("s4_active_127", 32'(active_count_out), 2);
    do_tick(1); wait_idle();
    chk("s4_active_128", 32'(active_count_out), 0);
    chk("s4_mix_128", 32'(mix_out), 512);
    do_tick(1); wait_idle();
    chk("s4_mix_after", 32'(mix_out), 512);

    mem[1] = 0; mem[0] = 16384; gate_in = 8'h01;
    do_tick(1);
    repeat (4) @(negedge clk_in);
    do_tick(0);
    chk("s5_overrun", 32'(overrun_out), 1);
    wait_idle();
    do_tick(1);
    repeat (11) @(negedge clk_in);
    chk("s5_busy_at_out", 32'(busy_out), 1);
    do_tick(0);
    wait_idle();
    repeat (20) @(negedge clk_in);
    chk("s5_overrun_sticky", 32'(overrun_out), 1);

    do_tick(0);
    repeat (5) @(negedge clk_in);
    chk("s6_busy_mid", 32'(busy_out), 1);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    for (int v = 0; v < NV; v++) begin mem[v] = 0; env_m[v] = 0; end
    repeat (20) @(negedge clk_in);
    chk("s6_mix", 32'(mix_out), 512);
    chk("s6_busy", 32'(busy_out), 0);
    chk("s6_overrun", 32'(overrun_out), 0);
    chk("s6_active", 32'(active_count_out), 0);
    mem[0] = 16384; gate_in = 8'h01;
    do_tick(1); wait_idle();
    chk("s6_mix_replay", 32'(mix_out), 520);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
